// File: rtl/xbar_pkg.sv
// Shared types and helpers for the product scatter crossbar.
// XBAR_SATURATE_EN selects saturating data conversion; otherwise sign+low bits.
package xbar_pkg;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ROUTE = 1'b1
    } xbar_state_t;

    function automatic logic [31:0] bank_map(
        input logic [31:0] row,
        input logic [31:0] col,
        input int          bank_count
    );
        logic [31:0] sum;
        sum = col + 32'd3 * row;
        return sum & (32'(bank_count) - 32'd1);
    endfunction

    function automatic logic [63:0] conv_data(
        input logic signed [63:0] d,
        input int                 out_w
    );
        logic signed [63:0] hi;
`ifdef XBAR_SATURATE_EN
        logic signed [63:0] lo;
`endif
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
`ifdef XBAR_SATURATE_EN
        lo = -hi - 64'sd1;
        if (d > hi)
            return hi;
        else if (d < lo)
            return lo;
        else
            return d;
`else
        return (d & hi) | (d[63] ? ~hi : 64'sd0);
`endif
    endfunction

endpackage

// File: rtl/xbar_bank_arbiter.sv
// Lowest-index-wins arbiter for one accumulator bank.
// Produces a one-hot grant plus the granted lane index.
module xbar_bank_arbiter #(
    parameter int NUM_LANES = 16,
    parameter int LW        = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic [NUM_LANES-1:0] req,
    output logic [NUM_LANES-1:0] gnt,
    output logic [LW-1:0]        idx,
    output logic                 vld
);

    // scan downward so the lowest requesting lane is the last to claim
    always_comb begin
        gnt = '0;
        idx = '0;
        vld = |req;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                idx    = LW'(i);
            end
        end
    end

endmodule

// File: rtl/product_scatter_xbar.sv
// Scatters a batch of signed products onto banked accumulator write ports.
// Bank conflicts are serialised over ROUTE cycles; XBAR_SATURATE_EN picks conversion.
module product_scatter_xbar
    import xbar_pkg::*;
#(
    parameter int NUM_LANES  = 16,
    parameter int BANK_COUNT = 32,
    parameter int COORD_W    = 8,
    parameter int IN_W       = 16,
    parameter int OUT_W      = 8
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [NUM_LANES-1:0]                 in_mask,
    input  logic [NUM_LANES-1:0][COORD_W-1:0]    in_row,
    input  logic [NUM_LANES-1:0][COORD_W-1:0]    in_col,
    input  logic [NUM_LANES-1:0][IN_W-1:0]       in_data,
    output logic [BANK_COUNT-1:0]                bank_we,
    output logic [BANK_COUNT-1:0][COORD_W-1:0]   bank_row,
    output logic [BANK_COUNT-1:0][COORD_W-1:0]   bank_col,
    output logic [BANK_COUNT-1:0][OUT_W-1:0]     bank_data,
    output logic                                 batch_done,
    output logic [15:0]                          conflict_cnt
);

    localparam int BW = $clog2(BANK_COUNT);
    localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    xbar_state_t state;
    xbar_state_t state_nxt;

    logic [NUM_LANES-1:0]              pend;
    logic [NUM_LANES-1:0][COORD_W-1:0] lat_row;
    logic [NUM_LANES-1:0][COORD_W-1:0] lat_col;
    logic [NUM_LANES-1:0][IN_W-1:0]    lat_data;

    logic [NUM_LANES-1:0][BW-1:0]      lane_bank;
    logic [NUM_LANES-1:0]              gnt_b [BANK_COUNT];
    logic [LW-1:0]                     idx_b [BANK_COUNT];
    logic [BANK_COUNT-1:0]             vld_b;
    logic [BANK_COUNT-1:0][OUT_W-1:0]  conv_b;
    logic [NUM_LANES-1:0]              granted;
    logic [NUM_LANES-1:0]              rest;
    logic                              accept;
    logic                              routing;
    logic                              last;

    assign accept  = in_valid && in_ready;
    assign routing = (state == S_ROUTE);
    assign rest    = pend & ~granted;
    assign last    = ~|rest;

    // bank target of every latched lane
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_bank[l] = BW'(bank_map(32'(lat_row[l]), 32'(lat_col[l]), BANK_COUNT));
        end
    end

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        logic [NUM_LANES-1:0] req;

        // pending lanes aimed at this bank
        always_comb begin
            for (int l = 0; l < NUM_LANES; l++) begin
                req[l] = pend[l] && (lane_bank[l] == BW'(b));
            end
        end

        xbar_bank_arbiter #(
            .NUM_LANES (NUM_LANES),
            .LW        (LW)
        ) u_arb (
            .req (req),
            .gnt (gnt_b[b]),
            .idx (idx_b[b]),
            .vld (vld_b[b])
        );
    end

    // union of all bank grants this cycle
    always_comb begin
        granted = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            granted = granted | gnt_b[b];
        end
    end

    // converted data of each bank's winning lane
    always_comb begin
        for (int b = 0; b < BANK_COUNT; b++) begin
            conv_b[b] = OUT_W'(conv_data(64'(signed'(lat_data[idx_b[b]])), OUT_W));
        end
    end

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // next-state: leave IDLE on a non-empty batch, return once drained
    always_comb begin
        state_nxt = state;
        unique case (1'b1)
            (state == S_IDLE):  if (accept && |in_mask) state_nxt = S_ROUTE;
            (state == S_ROUTE): if (last) state_nxt = S_IDLE;
            default:            state_nxt = S_IDLE;
        endcase
    end

    // handshake output: only idle accepts
    always_comb begin
        in_ready = (state == S_IDLE);
    end

    // batch capture and pending-lane retirement
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend     <= '0;
            lat_row  <= '0;
            lat_col  <= '0;
            lat_data <= '0;
        end else if (accept) begin
            pend     <= in_mask;
            lat_row  <= in_row;
            lat_col  <= in_col;
            lat_data <= in_data;
        end else if (routing) begin
            pend     <= rest;
        end
    end

    // registered bank write ports and completion pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_we    <= '0;
            bank_row   <= '0;
            bank_col   <= '0;
            bank_data  <= '0;
            batch_done <= 1'b0;
        end else begin
            batch_done <= (accept && ~|in_mask) || (routing && last);
            for (int b = 0; b < BANK_COUNT; b++) begin
                bank_we[b] <= routing && vld_b[b];
                if (routing && vld_b[b]) begin
                    bank_row[b]  <= lat_row[idx_b[b]];
                    bank_col[b]  <= lat_col[idx_b[b]];
                    bank_data[b] <= conv_b[b];
                end
            end
        end
    end

    // saturating count of cycles where some pending lane waited
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            conflict_cnt <= '0;
        else if (routing && |rest && conflict_cnt != 16'hFFFF)
            conflict_cnt <= conflict_cnt + 16'd1;
    end

endmodule

// File: tb/tb_product_scatter_xbar.sv
// Directed bench for product_scatter_xbar with default parameters.
// Expected data for 0x0123 depends on XBAR_SATURATE_EN.
module tb_product_scatter_xbar;

    localparam int NL = 16;
    localparam int NB = 32;
    localparam int CW = 8;
    localparam int IW = 16;
    localparam int OW = 8;

`ifdef XBAR_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [NL-1:0]            in_mask;
    logic [NL-1:0][CW-1:0]    in_row;
    logic [NL-1:0][CW-1:0]    in_col;
    logic [NL-1:0][IW-1:0]    in_data;
    logic [NB-1:0]            bank_we;
    logic [NB-1:0][CW-1:0]    bank_row;
    logic [NB-1:0][CW-1:0]    bank_col;
    logic [NB-1:0][OW-1:0]    bank_data;
    logic                     batch_done;
    logic [15:0]              conflict_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          lane;
        logic [7:0]  row;
        logic [7:0]  col;
        logic [15:0] data;
        int          bank;
        logic [7:0]  exp;
    } vec_t;

    vec_t tbl [7];

    product_scatter_xbar #(
        .NUM_LANES  (NL),
        .BANK_COUNT (NB),
        .COORD_W    (CW),
        .IN_W       (IW),
        .OUT_W      (OW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_mask      (in_mask),
        .in_row       (in_row),
        .in_col       (in_col),
        .in_data      (in_data),
        .bank_we      (bank_we),
        .bank_row     (bank_row),
        .bank_col     (bank_col),
        .bank_data    (bank_data),
        .batch_done   (batch_done),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clr();
        in_mask = '0;
        in_row  = '0;
        in_col  = '0;
        in_data = '0;
    endtask

    task automatic set_lane(input int l, input logic [7:0] r, input logic [7:0] c,
                            input logic [15:0] d);
        in_mask[l] = 1'b1;
        in_row[l]  = r;
        in_col[l]  = c;
        in_data[l] = d;
    endtask

    // offer one batch for a single edge; returns on the negedge after acceptance
    task automatic send();
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{0,  8'd1,   8'd30,  16'h0123, 1,  SAT ? 8'h7F : 8'h23};
        tbl[1] = '{3,  8'd0,   8'd5,   16'hFF00, 5,  8'h80};
        tbl[2] = '{15, 8'd10,  8'd2,   16'h0045, 0,  8'h45};
        tbl[3] = '{7,  8'd255, 8'd255, 16'h8000, 28, 8'h80};
        tbl[4] = '{2,  8'd4,   8'd9,   16'h007F, 21, 8'h7F};
        tbl[5] = '{9,  8'd2,   8'd200, 16'hFFFF, 14, 8'hFF};
        tbl[6] = '{5,  8'd0,   8'd31,  16'h0080, 31, SAT ? 8'h7F : 8'h00};

        reset_n  = 1'b0;
        in_valid = 1'b0;
        clr();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_we", 64'(bank_we), 64'd0);
        chk("rst_done", 64'(batch_done), 64'd0);
        chk("rst_cnt", 64'(conflict_cnt), 64'd0);
        chk("rst_data", 64'(bank_data[5]), 64'd0);

        for (int i = 0; i < 7; i++) begin
            clr();
            set_lane(tbl[i].lane, tbl[i].row, tbl[i].col, tbl[i].data);
            send();
            @(negedge clk);
            chk("tbl_we", 64'(bank_we), 64'(32'd1 << tbl[i].bank));
            chk("tbl_data", 64'(bank_data[tbl[i].bank]), 64'(tbl[i].exp));
            chk("tbl_row", 64'(bank_row[tbl[i].bank]), 64'(tbl[i].row));
            chk("tbl_col", 64'(bank_col[tbl[i].bank]), 64'(tbl[i].col));
            chk("tbl_done", 64'(batch_done), 64'd1);
            @(negedge clk);
            chk("tbl_idle_we", 64'(bank_we), 64'd0);
            chk("tbl_idle_done", 64'(batch_done), 64'd0);
        end

        clr();
        for (int l = 0; l < NL; l++) set_lane(l, 8'd0, 8'(l), 16'(l));
        send();
        chk("noconf_busy", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("noconf_we", 64'(bank_we), 64'h0000_FFFF);
        chk("noconf_done", 64'(batch_done), 64'd1);
        chk("noconf_data7", 64'(bank_data[7]), 64'd7);
        chk("noconf_col15", 64'(bank_col[15]), 64'd15);
        chk("noconf_cnt", 64'(conflict_cnt), 64'd0);

        clr();
        for (int l = 0; l < 4; l++) set_lane(l, 8'd0, 8'd5, 16'(10 + l));
        send();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("conf_we", 64'(bank_we), 64'(32'd1 << 5));
            chk("conf_data", 64'(bank_data[5]), 64'(10 + i));
            chk("conf_done", 64'(batch_done), 64'(i == 3));
        end
        chk("conf_cnt", 64'(conflict_cnt), 64'd3);

        clr();
        send();
        chk("empty_done", 64'(batch_done), 64'd1);
        chk("empty_we", 64'(bank_we), 64'd0);
        chk("empty_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("empty_done_off", 64'(batch_done), 64'd0);
        chk("empty_we_off", 64'(bank_we), 64'd0);

        clr();
        for (int l = 0; l < 3; l++) set_lane(l, 8'd0, 8'd5, 16'(20 + l));
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        clr();
        set_lane(0, 8'd0, 8'd7, 16'h0021);
        set_lane(1, 8'd0, 8'd5, 16'h0055);
        set_lane(2, 8'd0, 8'd5, 16'h0066);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_we", 64'(bank_we), 64'(32'd1 << 5));
            chk("bp_data", 64'(bank_data[5]), 64'(20 + i));
            chk("bp_ready", 64'(in_ready), 64'(i == 2));
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_accept_we", 64'(bank_we), 64'd0);
        chk("bp_accept_busy", 64'(in_ready), 64'd0);
        chk("bp_cnt", 64'(conflict_cnt), 64'd5);
        @(negedge clk);
        chk("bp_next_we", 64'(bank_we), 64'((32'd1 << 7) | (32'd1 << 5)));
        chk("bp_next_data", 64'(bank_data[7]), 64'h21);
        chk("bp_next_data5", 64'(bank_data[5]), 64'h55);
        @(negedge clk);
        chk("bp_tail_data5", 64'(bank_data[5]), 64'h66);
        chk("bp_tail_done", 64'(batch_done), 64'd1);

        clr();
        for (int l = 0; l < 3; l++) set_lane(l, 8'd3, 8'd9, 16'(40 + l));
        send();
        @(negedge clk);
        chk("mid_first_we", 64'(bank_we), 64'(32'd1 << 18));
        chk("mid_first_data", 64'(bank_data[18]), 64'd40);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_we", 64'(bank_we), 64'd0);
        chk("mid_rst_data", 64'(bank_data[18]), 64'd0);
        chk("mid_rst_row", 64'(bank_row[18]), 64'd0);
        chk("mid_rst_col", 64'(bank_col[18]), 64'd0);
        chk("mid_rst_done", 64'(batch_done), 64'd0);
        chk("mid_rst_cnt", 64'(conflict_cnt), 64'd0);
        chk("mid_rst_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("mid_after_we", 64'(bank_we), 64'd0);
            chk("mid_after_done", 64'(batch_done), 64'd0);
        end
        chk("mid_after_ready", 64'(in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/product_scatter_xbar.md
PRODUCT_SCATTER_XBAR -- requirements
Module: product_scatter_xbar

Interface
REQ-001 SHALL have parameter NUM_LANES, default 16: products accepted per batch.
REQ-002 SHALL have parameter BANK_COUNT, default 32: accumulator buffer banks; power of two, at least 2.
REQ-003 SHALL have parameter COORD_W, default 8: row and column coordinate width.
REQ-004 SHALL have parameter IN_W, default 16: signed product width.
REQ-005 SHALL have parameter OUT_W, default 8: signed bank data width; OUT_W <= IN_W.
REQ-006 SHALL have port clk, input, 1 bit: clock.
REQ-007 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port in_valid, input, 1 bit: batch offered.
REQ-009 SHALL have port in_ready, output, 1 bit: batch can be accepted.
REQ-010 SHALL have port in_mask, input, NUM_LANES bits: lane carries a product.
REQ-011 SHALL have port in_row and port in_col, input, NUM_LANES x COORD_W each: per-lane coordinates.
REQ-012 SHALL have port in_data, input, NUM_LANES x IN_W: per-lane signed product.
REQ-013 SHALL have port bank_we, output, BANK_COUNT bits: per-bank write enable.
REQ-014 SHALL have port bank_row and port bank_col, output, BANK_COUNT x COORD_W each: write coordinates.
REQ-015 SHALL have port bank_data, output, BANK_COUNT x OUT_W: write data.
REQ-016 SHALL have port batch_done, output, 1 bit: one-cycle pulse on the final write of a batch.
REQ-017 SHALL have port conflict_cnt, output, 16 bits: saturating count of ROUTE cycles in which at least one pending lane lost arbitration.

Function
REQ-018 SHALL run a two-state FSM, IDLE and ROUTE; in_ready SHALL be 1 only in IDLE.
REQ-019 SHALL accept a batch on any edge where in_valid and in_ready are both 1, latching mask, coordinates and data into internal registers; pending = in_mask.
REQ-020 SHALL go IDLE->ROUTE on acceptance with nonzero mask; on acceptance with zero mask SHALL stay IDLE, issue no writes and pulse batch_done on the next cycle.
REQ-021 SHALL map each lane to bank = (col + 3*row) mod BANK_COUNT, computed on the latched values.
REQ-022 SHALL, in each ROUTE cycle and for each bank, grant the lowest-indexed pending lane targeting it; all other lanes stay pending.
REQ-023 SHALL register granted writes, so bank_we/row/col/data are valid the cycle after the grant; ungranted banks SHALL drive bank_we=0 and hold row/col/data.
REQ-024 SHALL clear granted lanes from pending at the grant edge; when pending becomes zero SHALL go ROUTE->IDLE and assert batch_done in the same output cycle as the final writes.
REQ-025 Minimum latency SHALL be acceptance edge E0, writes visible after E1; a batch with k lanes on the same bank SHALL complete in exactly k ROUTE cycles.
REQ-026 Data conversion SHALL follow the configuration rule (Configuration section).
REQ-027 conflict_cnt SHALL increment once per qualifying cycle, hold at 16'hFFFF and never wrap.
REQ-028 in_valid while in ROUTE SHALL be ignored; inputs SHALL not be sampled.

Reset
REQ-029 Reset SHALL force IDLE, pending=0, bank_we=0, bank_row=0, bank_col=0, bank_data=0, batch_done=0, conflict_cnt=0; in_ready SHALL be 1 after release.
REQ-030 Reset mid-ROUTE SHALL discard the batch with no further writes.

Configuration
REQ-031 SHALL use macro XBAR_SATURATE_EN: when defined, data SHALL saturate to the signed OUT_W range; when undefined, data SHALL be {sign bit, IN_W low OUT_W-1 bits}.

Structure
REQ-032 SHALL place the FSM state typedef, the bank-mapping function and the conversion function in shared package xbar_pkg.
REQ-033 SHALL place per-bank lowest-index arbitration in sub-module xbar_bank_arbiter, instantiated BANK_COUNT times.

Verification
REQ-034 Scenario, no conflict: 16 lanes, row 0, col 0..15 -> one ROUTE cycle, bank_we[15:0] all 1, batch_done with those writes.
REQ-035 Scenario, full conflict: 4 lanes all at (0,5) -> bank 5 written on 4 consecutive cycles in lane order 0..3, conflict_cnt=3.
REQ-036 Scenario, mapping: lane row 1, col 30 with BANK_COUNT=32 -> bank 1 written.
REQ-037 Scenario, conversion: data 16'sh0123 -> 8'h7F with XBAR_SATURATE_EN defined, 8'h23 with it undefined; data 16'shFF00 -> 8'h80 in both cases.
REQ-038 Scenario, empty and back-pressure: zero mask -> batch_done only, no writes; in_valid held during ROUTE -> next batch accepted only after return to IDLE.
REQ-039 Scenario, reset mid-ROUTE: after 1 of 3 conflicting writes -> all outputs 0, in_ready=1, no writes follow.
